// File: rtl/fg_dac_spi.sv
// fg_dac_spi -- output stage behind the waveform generator.
//
// Adds a signed DC offset to the generator sample. The sum is saturated to the
// unsigned range 0..2^WAVEFORM_BITWIDTH-1 and truncated to the DAC code width.
// Each accepted sample is then shifted out to an SPI DAC (mode 0, MSB first),
// one frame per sample strobe.
//
// Optional feature: define FG_DAC_CMD_HEADER_EN to send CMD_BYTE ahead of
// the DAC code. Each frame is then DAC_BITWIDTH+8 bits long.
//
// Ports:
//   clk_i       system clock
//   rstn_i      asynchronous active-low reset
//   clk_en_i    sample strobe (one-cycle pulse, same as the generator enable)
//   wave_i      signed generator sample, WAVEFORM_BITWIDTH+1 bits
//   offset_i    signed DC offset, WAVEFORM_BITWIDTH+1 bits
//   clk_div_i   SCLK half-period minus one, in clk_i cycles
//   spi_sclk_o  SPI clock (idles low)
//   spi_mosi_o  SPI data
//   spi_csn_o   SPI chip select, active-low
//   busy_o      high while a frame is in progress
//   drop_o      one-cycle pulse when a strobe is discarded because a frame is busy
module fg_dac_spi #(
  parameter int          WAVEFORM_BITWIDTH = 16,
  parameter int          DAC_BITWIDTH      = 16,
  parameter int          DIV_BITWIDTH      = 8,
  parameter logic [7:0]  CMD_BYTE          = 8'h30
) (
  input  logic                                clk_i,
  input  logic                                rstn_i,
  input  logic                                clk_en_i,
  input  logic signed [WAVEFORM_BITWIDTH:0]   wave_i,
  input  logic signed [WAVEFORM_BITWIDTH:0]   offset_i,
  input  logic        [DIV_BITWIDTH-1:0]      clk_div_i,
  output logic                                spi_sclk_o,
  output logic                                spi_mosi_o,
  output logic                                spi_csn_o,
  output logic                                busy_o,
  output logic                                drop_o
);

  localparam int WB = WAVEFORM_BITWIDTH;
`ifdef FG_DAC_CMD_HEADER_EN
  localparam int N = DAC_BITWIDTH + 8;
`else
  localparam int N = DAC_BITWIDTH;
`endif
  localparam int BCW = $clog2(N + 1);
  localparam logic signed [WB+1:0] MAXV = {2'b00, {WB{1'b1}}};

  // Clamp to 0..2^WB-1, then keep the upper DAC_BITWIDTH bits.
  function automatic logic [DAC_BITWIDTH-1:0] sat_trunc(input logic signed [WB+1:0] s);
    logic [WB-1:0] u;
    if (s < 0)
      u = '0;
    else if (s > MAXV)
      u = '1;
    else
      u = s[WB-1:0];
    return DAC_BITWIDTH'(u >> (WB - DAC_BITWIDTH));
  endfunction

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t                  state_q;
  logic [N-1:0]            sh_q;
  logic [N-1:0]            sh_d;
  logic [DIV_BITWIDTH-1:0] cnt_q;
  logic [DIV_BITWIDTH-1:0] div_q;
  logic [BCW-1:0]          bitcnt_q;
  logic                    sclk_q;
  logic                    mosi_q;
  logic                    csn_q;
  logic                    busy_q;
  logic                    drop_q;

  logic signed [WB+1:0]    sum;
  logic [DAC_BITWIDTH-1:0] code;
  logic [N-1:0]            frame_w;

  // One bit of headroom so that wave+offset cannot wrap.
  assign sum  = $signed({wave_i[WB], wave_i}) + $signed({offset_i[WB], offset_i});
  assign code = sat_trunc(sum);
  // The header byte sits above the code. Without the header, N equals the
  // code width and the cast drops the header byte.
  assign frame_w = N'({CMD_BYTE, code});
  assign sh_d    = sh_q << 1;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      sh_q     <= '0;
      cnt_q    <= '0;
      div_q    <= '0;
      bitcnt_q <= '0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      csn_q    <= 1'b1;
      busy_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (clk_en_i) begin
            sh_q     <= frame_w;
            mosi_q   <= frame_w[N-1];
            csn_q    <= 1'b0;
            sclk_q   <= 1'b0;
            cnt_q    <= '0;
            bitcnt_q <= '0;
            div_q    <= clk_div_i;
            busy_q   <= 1'b1;
            state_q  <= SHIFT;
          end
        end
        SHIFT: begin
          drop_q <= clk_en_i;
          if (cnt_q == div_q) begin
            cnt_q  <= '0;
            sclk_q <= ~sclk_q;
            // A falling edge: present the next bit for a full half-period.
            if (sclk_q) begin
              sh_q   <= sh_d;
              mosi_q <= sh_d[N-1];
              if (bitcnt_q == BCW'(N - 1))
                state_q <= HOLD;
              else
                bitcnt_q <= bitcnt_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        HOLD: begin
          drop_q <= clk_en_i;
          if (cnt_q == div_q) begin
            cnt_q   <= '0;
            csn_q   <= 1'b1;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign spi_sclk_o = sclk_q;
  assign spi_mosi_o = mosi_q;
  assign spi_csn_o  = csn_q;
  assign busy_o     = busy_q;
  assign drop_o     = drop_q;

endmodule

// File: tb/tb_fg_dac_spi.sv
module tb_fg_dac_spi;

`ifdef FG_DAC_CMD_HEADER_EN
  localparam int          HB   = 8;
  localparam logic [31:0] HDRV = 32'h30;
`else
  localparam int          HB   = 0;
  localparam logic [31:0] HDRV = 32'h0;
`endif
  localparam int N16 = 16 + HB;
  localparam int N12 = 12 + HB;

  logic               clk_i = 1'b0;
  logic               rstn_i = 1'b1;
  logic               clk_en_i = 1'b0;
  logic signed [16:0] wave_i = '0;
  logic signed [16:0] offset_i = '0;
  logic [7:0]         clk_div_i = '0;

  logic sclk16, mosi16, csn16, busy16, drop16;
  logic sclk12, mosi12, csn12, busy12, drop12;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  fg_dac_spi #(.WAVEFORM_BITWIDTH(16), .DAC_BITWIDTH(16), .DIV_BITWIDTH(8), .CMD_BYTE(8'h30)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .clk_en_i(clk_en_i), .wave_i(wave_i),
    .offset_i(offset_i), .clk_div_i(clk_div_i), .spi_sclk_o(sclk16),
    .spi_mosi_o(mosi16), .spi_csn_o(csn16), .busy_o(busy16), .drop_o(drop16));

  fg_dac_spi #(.WAVEFORM_BITWIDTH(16), .DAC_BITWIDTH(12), .DIV_BITWIDTH(8), .CMD_BYTE(8'h30)) dut12 (
    .clk_i(clk_i), .rstn_i(rstn_i), .clk_en_i(clk_en_i), .wave_i(wave_i),
    .offset_i(offset_i), .clk_div_i(clk_div_i), .spi_sclk_o(sclk12),
    .spi_mosi_o(mosi12), .spi_csn_o(csn12), .busy_o(busy12), .drop_o(drop12));

  // Issue one strobe, then scramble the inputs, which should be ignored.
  task automatic send(input logic signed [16:0] w, input logic signed [16:0] o);
    @(negedge clk_i);
    wave_i   = w;
    offset_i = o;
    clk_en_i = 1'b1;
    @(posedge clk_i);
    #1;
    clk_en_i = 1'b0;
    wave_i   = 17'sh0AAAA;
    offset_i = 17'sh05555;
  endtask

  task automatic capture(input int cycles,
                         output logic [31:0] b16, output int r16, output int l16,
                         output logic [31:0] b12, output int r12, output int bm);
    logic p16, p12;
    b16 = '0; b12 = '0; r16 = 0; r12 = 0; l16 = 0; bm = 0;
    p16 = 1'b0; p12 = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_i);
      if (sclk16 && !p16) begin b16 = {b16[30:0], mosi16}; r16++; end
      if (sclk12 && !p12) begin b12 = {b12[30:0], mosi12}; r12++; end
      p16 = sclk16;
      p12 = sclk12;
      if (!csn16) l16++;
      if (busy16 !== !csn16) bm++;
    end
  endtask

  task automatic test_reset();
    int bad;
    rstn_i = 1'b1;
    #1;
    rstn_i = 1'b0;
    repeat (3) @(negedge clk_i);
    n_cmp++; if (csn16 !== 1'b1) begin n_err++; $display("FAIL reset_csn got=%b exp=1", csn16); end
    n_cmp++; if (sclk16 !== 1'b0) begin n_err++; $display("FAIL reset_sclk got=%b exp=0", sclk16); end
    n_cmp++; if (mosi16 !== 1'b0) begin n_err++; $display("FAIL reset_mosi got=%b exp=0", mosi16); end
    n_cmp++; if (busy16 !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy16); end
    n_cmp++; if (drop16 !== 1'b0) begin n_err++; $display("FAIL reset_drop got=%b exp=0", drop16); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (csn16 !== 1'b1 || sclk16 !== 1'b0 || mosi16 !== 1'b0 || busy16 !== 1'b0) bad++;
    end
    @(negedge clk_i);
    rstn_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_i);
      if (csn16 !== 1'b1 || sclk16 !== 1'b0 || mosi16 !== 1'b0 || busy16 !== 1'b0 || drop16 !== 1'b0) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL reset_idle bad_cycles=%0d exp=0", bad); end
  endtask

  task automatic test_frame(input string nm, input logic signed [16:0] w, input logic signed [16:0] o,
                            input logic [31:0] c16, input logic [31:0] c12);
    logic [31:0] b16, b12, e16, e12;
    int r16, l16, r12, bm;
    e16 = (HDRV << 16) | c16;
    e12 = (HDRV << 12) | c12;
    clk_div_i = 8'd0;
    send(w, o);
    capture(2 * N16 + 1 + 6, b16, r16, l16, b12, r12, bm);
    n_cmp++; if (b16 !== e16) begin n_err++; $display("FAIL %s_bits16 got=%h exp=%h", nm, b16, e16); end
    n_cmp++; if (r16 !== N16) begin n_err++; $display("FAIL %s_rises16 got=%0d exp=%0d", nm, r16, N16); end
    n_cmp++; if (l16 !== 2 * N16 + 1) begin n_err++; $display("FAIL %s_csnlow got=%0d exp=%0d", nm, l16, 2 * N16 + 1); end
    n_cmp++; if (bm !== 0) begin n_err++; $display("FAIL %s_busy_vs_csn got=%0d exp=0", nm, bm); end
    n_cmp++; if (b12 !== e12) begin n_err++; $display("FAIL %s_bits12 got=%h exp=%h", nm, b12, e12); end
    n_cmp++; if (r12 !== N12) begin n_err++; $display("FAIL %s_rises12 got=%0d exp=%0d", nm, r12, N12); end
  endtask

  task automatic test_overrun();
    int f, exp_drops, acc2, drops, falls, fall2_c;
    logic pcsn;
    f = (2 * N16 + 1) * 4;
    exp_drops = f / 10;
    acc2 = (f / 10 + 1) * 10;
    drops = 0; falls = 0; fall2_c = -1; pcsn = 1'b1;
    clk_div_i = 8'd3;
    wave_i = 17'sh01234;
    offset_i = '0;
    for (int c = 0; c <= acc2 + 3; c++) begin
      @(negedge clk_i);
      if (c > 0) begin
        if (drop16) drops++;
        if (!csn16 && pcsn) begin
          falls++;
          if (falls == 2) fall2_c = c;
        end
      end
      pcsn = csn16;
      clk_en_i = ((c % 10) == 0) && (c <= acc2);
    end
    clk_en_i = 1'b0;
    n_cmp++; if (drops !== exp_drops) begin n_err++; $display("FAIL overrun_drops got=%0d exp=%0d", drops, exp_drops); end
    n_cmp++; if (fall2_c !== acc2 + 1) begin n_err++; $display("FAIL overrun_next_start got=%0d exp=%0d", fall2_c, acc2 + 1); end
    repeat (f + 10) @(negedge clk_i);
    n_cmp++; if (busy16 !== 1'b0) begin n_err++; $display("FAIL overrun_end_busy got=%b exp=0", busy16); end
    clk_div_i = 8'd0;
  endtask

  task automatic test_reset_midframe();
    int bad;
    clk_div_i = 8'd0;
    send(17'sh01234, 17'sh00000);
    repeat (15) @(negedge clk_i);
    n_cmp++; if (csn16 !== 1'b0) begin n_err++; $display("FAIL mid_in_frame csn got=%b exp=0", csn16); end
    #2;
    rstn_i = 1'b0;
    #1;
    n_cmp++; if (csn16 !== 1'b1) begin n_err++; $display("FAIL mid_async_csn got=%b exp=1", csn16); end
    n_cmp++; if (sclk16 !== 1'b0) begin n_err++; $display("FAIL mid_async_sclk got=%b exp=0", sclk16); end
    n_cmp++; if (busy16 !== 1'b0) begin n_err++; $display("FAIL mid_async_busy got=%b exp=0", busy16); end
    @(negedge clk_i);
    rstn_i = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (sclk16 !== 1'b0 || csn16 !== 1'b1 || busy16 !== 1'b0) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL mid_after_release bad_cycles=%0d exp=0", bad); end
  endtask

  initial begin
    test_reset();
    test_frame("normal", 17'sh01234, 17'sh00000, 32'h1234, 32'h123);
    test_frame("sat_hi", 17'sh0FFF0, 17'sh00020, 32'hFFFF, 32'hFFF);
    test_frame("sat_lo", 17'sh00005, -17'sd10,   32'h0000, 32'h000);
    test_frame("trunc",  17'sh0ABCD, 17'sh00000, 32'hABCD, 32'hABC);
    test_frame("hdr",    17'sh000FF, 17'sh00000, 32'h00FF, 32'h00F);
    test_frame("negoff", 17'sh08000, -17'sh01000, 32'h7000, 32'h700);
    test_overrun();
    test_reset_midframe();
    test_frame("after_rst", 17'sh05A5A, 17'sh00101, 32'h5B5B, 32'h5B5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fg_dac_spi.md
Name: fg_dac_spi

Overview:
- Output stage directly downstream of the waveform generator.
- Takes the generator's 17-bit signed sample and adds a signed DC offset, then saturates and truncates the result to the DAC code width.
- Serializes each accepted sample to an external SPI DAC: mode 0, MSB first, one frame per sample strobe.
- Paced by the same clk_en_i strobe that advances the generator.

Parameters:
- WAVEFORM_BITWIDTH, 16, generator amplitude width; wave_i is WAVEFORM_BITWIDTH+1 bits signed.
- DAC_BITWIDTH, 16, DAC code width; legal range 1..WAVEFORM_BITWIDTH.
- DIV_BITWIDTH, 8, width of the SCLK divider input.
- CMD_BYTE, 8'h30, command header byte (used only with FG_DAC_CMD_HEADER_EN).

Ports:
- clk_i  in  1  system clock.
- rstn_i  in  1  reset; asynchronous, active-low.
- clk_en_i  in  1  sample strobe; one-cycle pulse, same as the generator's enable.
- wave_i  in  WAVEFORM_BITWIDTH+1  signed sample from the waveform generator.
- offset_i  in  WAVEFORM_BITWIDTH+1  signed DC offset.
- clk_div_i  in  DIV_BITWIDTH  SCLK half-period minus one, in clk_i cycles.
- spi_sclk_o  out  1  SPI clock.
- spi_mosi_o  out  1  SPI data.
- spi_csn_o  out  1  SPI chip select, active-low.
- busy_o  out  1  high while a frame is in progress.
- drop_o  out  1  one-cycle pulse when a strobe arrives while busy.

Behaviour:
- Reset (async, rstn_i=0): state IDLE; spi_sclk_o=0, spi_mosi_o=0, spi_csn_o=1, busy_o=0, drop_o=0; shift register and counters cleared.
- Reset asserted mid-frame aborts the frame immediately: CSN high, SCLK low, no partial-frame completion after release.
- Arithmetic:
  - sum = wave_i + offset_i, computed in WAVEFORM_BITWIDTH+2 bits signed.
  - Saturate to the unsigned range 0..2^WAVEFORM_BITWIDTH-1: negative sum -> 0; sum > max -> max.
  - DAC code = upper DAC_BITWIDTH bits of the saturated value (truncation, no rounding).
- Frame length N = DAC_BITWIDTH, or DAC_BITWIDTH+8 with the header enabled.
- Half-period H = clk_div_i+1; clk_div_i is latched at accept and held for the whole frame.
- States:
  - IDLE: clk_en_i=1 -> accept at that edge: load code into the shift register, spi_csn_o<=0, spi_mosi_o<=MSB, spi_sclk_o stays 0 -> SHIFT.
  - SHIFT:
    - A half-period counter toggles SCLK every H cycles, starting low.
    - On each falling edge, MOSI advances to the next bit.
    - MOSI is stable for H cycles before each rising edge.
    - After the Nth falling edge -> HOLD, SCLK held low.
  - HOLD: after H cycles, spi_csn_o<=1, spi_mosi_o<=0 -> IDLE.
- Total frame time, accept edge to CSN high: (2N+1)*H cycles. Example: N=16, H=1 gives 33.
- busy_o = (state != IDLE); it is registered and goes high on the cycle after the accept edge.
- Strobe rules:
  - clk_en_i in SHIFT or HOLD: sample discarded, drop_o pulses for that one cycle, frame unaffected.
  - clk_en_i on the same edge that returns HOLD->IDLE: sample discarded with drop_o; a new frame needs a strobe while in IDLE.
- wave_i and offset_i are sampled only on the accept edge; changes during a frame are ignored.

Optional Feature:
- Macro FG_DAC_CMD_HEADER_EN.
- Defined: CMD_BYTE is shifted first, MSB first, then the DAC code; N = DAC_BITWIDTH+8.
- Not defined: data only; N = DAC_BITWIDTH and CMD_BYTE is unused.
- Saturation and timing rules are otherwise identical in both builds.

Test Plan:
- Reset, then idle 20 cycles -> csn=1, sclk=0, mosi=0, busy=0 throughout; 16 cycles of inactivity after rstn release with no strobe.
- Normal frame: wave=16'h1234, offset=0, clk_div=0, strobe, no header -> 16 SCLK rising edges; bits 0x1234 MSB first sampled on rising edges; csn low for exactly 33 cycles; busy falls with csn.
- Saturation:
  - wave=16'hFFF0, offset=+32 -> frame carries 16'hFFFF.
  - wave=5, offset=-10 -> frame carries 16'h0000.
  - DAC_BITWIDTH=12, wave=16'hABCD -> 12'hABC.
- Overrun: strobe every 10 cycles with clk_div=3 -> only the first strobe is sent; drop_o pulses once for each strobe during the frame; next frame starts at the first strobe after busy falls.
- Reset mid-frame: assert rstn_i=0 at bit 7 -> csn high and sclk low in the same cycle, asynchronously; after release, no SCLK edges until a new strobe.
- FG_DAC_CMD_HEADER_EN defined, wave=16'h00FF -> 24 rising edges carrying 0x30 then 0x00FF; csn low for 49 cycles at clk_div=0.
